// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the access controller: request/ack handshake plus address and data.
// The controller owns the request side; the memory owns ack and read data.
interface mem_access_ctrl_if #(
  parameter int AW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack;
  logic [15:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-access memory controller: IDLE -> REQ -> DONE, with a bounded wait for mem_ack.
// Every output is a flop; strobes (MR, MW, err) are one-cycle pulses.
module mem_access_ctrl #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  mem_access_ctrl_if.master mem,
  output logic          MR,
  output logic          MW,
  output logic [15:0]   W_IN,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state;
  logic       rnw_q;
  logic [7:0] wait_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rnw_q         <= 1'b0;
      wait_cnt      <= 8'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= 16'd0;
      MR            <= 1'b0;
      MW            <= 1'b0;
      W_IN          <= 16'd0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      MR  <= 1'b0;
      MW  <= 1'b0;
      err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rnw_q         <= rnw;
            mem.mem_addr  <= addr;
            mem.mem_wdata <= wdata;
            wait_cnt      <= 8'd0;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= ~rnw;
            busy          <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          if (mem.mem_ack) begin
            // An ack on the final allowed cycle still completes the access.
            if (rnw_q) W_IN <= mem.mem_rdata;
            MR          <= rnw_q;
            MW          <= ~rnw_q;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= DONE;
          end else if (wait_cnt + 8'd1 == TIMEOUT_C) begin
            wait_cnt    <= wait_cnt + 8'd1;
            err         <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of accesses scored through a queue, plus hand-driven
// sequences for busy rejection, ack outside REQ and reset in the middle of a request.
module tb_mem_access_ctrl;
  localparam int AW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rnw;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic          MR;
  logic          MW;
  logic [15:0]   W_IN;
  logic          busy;
  logic          err;

  mem_access_ctrl_if #(.AW(AW)) mem ();

  mem_access_ctrl #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rnw   (rnw),
    .addr  (addr),
    .wdata (wdata),
    .mem   (mem.master),
    .MR    (MR),
    .MW    (MW),
    .W_IN  (W_IN),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_at;      // REQ cycle index carrying the ack; >= TO means never
    int          req_cycles;
    logic        mr;
    logic        mw;
    logic        er;
    logic        bsy;
    logic [15:0] w_in;
  } vec_t;

  typedef struct {
    int          req_cycles;
    logic        mr;
    logic        mw;
    logic        er;
    logic        bsy;
    logic [15:0] w_in;
  } exp_t;

  exp_t sb[$];

  int mr_pulses = 0;
  int mw_pulses = 0;
  int overlap   = 0;

  always @(negedge clk) begin
    if (MR === 1'b1) mr_pulses++;
    if (MW === 1'b1) mw_pulses++;
    if (MR === 1'b1 && MW === 1'b1) overlap++;
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_access(input vec_t v, input string tag);
    exp_t e;
    int   n;
    e = '{v.req_cycles, v.mr, v.mw, v.er, v.bsy, v.w_in};
    start = 1'b1;
    rnw   = v.rnw;
    addr  = v.addr;
    wdata = v.wdata;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    addr  = 16'hFFFF;
    wdata = 16'hDEAD;
    n = 0;
    while (mem.mem_req === 1'b1 && n < 300) begin
      check({tag, " bus"}, {busy, MR, MW, mem.mem_we, mem.mem_addr, mem.mem_wdata},
            {1'b1, 1'b0, 1'b0, ~v.rnw, v.addr, v.wdata});
      if (n == v.ack_at) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = v.rdata;
      end else begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 16'h0BAD;
      end
      @(negedge clk);
      n++;
    end
    mem.mem_ack = 1'b0;
    e = sb.pop_front();
    check({tag, " req_cycles"}, 64'(n), 64'(e.req_cycles));
    check({tag, " result"}, {MR, MW, err, busy, W_IN}, {e.mr, e.mw, e.er, e.bsy, e.w_in});
    @(negedge clk);
    check({tag, " back_idle"}, {MR, MW, err, busy, mem.mem_req}, 5'b0);
  endtask

  vec_t tbl[8];
  vec_t post;
  int   base_mr;
  int   base_mw;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 16'h0040, 16'h0000, 16'hBEEF, 0,  1,  1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tbl[1] = '{1'b0, 16'h0010, 16'h1234, 16'h5555, 3,  4,  1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b1, 16'h0123, 16'h0000, 16'h5A5A, 2,  3,  1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A};
    tbl[3] = '{1'b1, 16'h0456, 16'h0000, 16'h1111, 99, TO, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5A5A};
    tbl[4] = '{1'b0, 16'hFFFF, 16'hA5A5, 16'h0000, TO-1, TO, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5A5A};
    tbl[5] = '{1'b1, 16'h8000, 16'h0000, 16'hC0DE, TO-1, TO, 1'b1, 1'b0, 1'b0, 1'b1, 16'hC0DE};
    tbl[6] = '{1'b0, 16'h0001, 16'h9999, 16'h0000, 99, TO, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC0DE};
    tbl[7] = '{1'b1, 16'h0002, 16'h0000, 16'h0001, 1,  2,  1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};

    reset         = 1'b1;
    start         = 1'b0;
    rnw           = 1'b0;
    addr          = '0;
    wdata         = 16'd0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 16'd0;
    #1;
    check("reset_state",
          {mem.mem_req, mem.mem_we, MR, MW, err, busy, mem.mem_addr, mem.mem_wdata, W_IN}, 54'd0);

    // Deassert at a negedge and start at once: the first rising edge must accept it.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) do_access(tbl[i], $sformatf("vec%0d", i));

    // Ack while idle must not start or complete anything.
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 16'hEEEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ack", {busy, MR, MW, err, mem.mem_req, W_IN}, {5'b0, 16'h0001});
    end
    mem.mem_ack = 1'b0;

    // Second start while busy is dropped: address held, one MR only, nothing queued.
    base_mr = mr_pulses;
    base_mw = mw_pulses;
    start = 1'b1;
    rnw   = 1'b1;
    addr  = 16'h0200;
    @(negedge clk);
    addr = 16'h0099;
    @(negedge clk);
    start = 1'b0;
    check("busy_addr_held", {mem.mem_req, mem.mem_addr}, {1'b1, 16'h0200});
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 16'h7777;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    check("busy_done", {MR, MW, W_IN, mem.mem_req}, {1'b1, 1'b0, 16'h7777, 1'b0});
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("busy_not_queued", {busy, mem.mem_req}, 2'b00);
    check("busy_one_strobe", 64'(mr_pulses - base_mr + mw_pulses - base_mw), 64'd1);

    // Reset in the middle of a read: request drops at once, no strobe ever follows.
    base_mr = mr_pulses;
    start = 1'b1;
    rnw   = 1'b1;
    addr  = 16'h0300;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_req_active", {mem.mem_req, busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("mid_req_reset", {mem.mem_req, mem.mem_we, busy, MR, W_IN}, 20'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("mid_req_no_mr", 64'(mr_pulses - base_mr), 64'd0);
    post = '{1'b1, 16'h0301, 16'h0000, 16'h4321, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4321};
    do_access(post, "post_reset");

    check("mr_mw_exclusive", 64'(overlap), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
